// File: rtl/alu_rr_scheduler.sv
// Two-requester round-robin front end for one shared registered 8-bit signed ALU; one op per LAT+3 cycles.
// Request ready only in IDLE; response held until rsp_ready. Define ALU_RR_SCHED_STATS_EN for grant counters.
module alu_rr_scheduler #(
  parameter int unsigned LAT = 1,
  parameter int unsigned OPW = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic signed [7:0]   req0_a,
  input  logic signed [7:0]   req0_b,
  input  logic [OPW-1:0]      req0_op,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic signed [7:0]   req1_a,
  input  logic signed [7:0]   req1_b,
  input  logic [OPW-1:0]      req1_op,
  output logic                alu_start,
  output logic signed [7:0]   alu_a,
  output logic signed [7:0]   alu_b,
  output logic [OPW-1:0]      alu_op,
  input  logic signed [15:0]  alu_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic signed [15:0]  rsp_result,
`ifdef ALU_RR_SCHED_STATS_EN
  output logic                busy,
  output logic [15:0]         grant_cnt0,
  output logic [15:0]         grant_cnt1
`else
  output logic                busy
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CW = 4;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          last_grant;
  logic          own_id;
  logic          grant_id;
  logic          accept;

  // Contention goes to whoever was not granted last; a lone requester always wins.
  always_comb begin
    grant_id   = req1_valid;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end
    if (state == IDLE && (req0_valid || req1_valid)) begin
      accept     = 1'b1;
      req0_ready = ~grant_id;
      req1_ready = grant_id;
    end
  end

  always_comb begin
    state_nxt = state;
    alu_start = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        alu_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      last_grant <= 1'b1;
      own_id     <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_a      <= grant_id ? req1_a  : req0_a;
        alu_b      <= grant_id ? req1_b  : req0_b;
        alu_op     <= grant_id ? req1_op : req0_op;
        own_id     <= grant_id;
        last_grant <= grant_id;
      end
      // Counter reaches zero on the cycle whose closing edge carries the valid result.
      if (state == ISSUE) begin
        wait_cnt <= CW'(LAT - 1);
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (state == WAIT && wait_cnt == '0) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= own_id;
        rsp_result <= alu_result;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_RR_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_valid && req0_ready) begin
        grant_cnt0 <= grant_cnt0 + 16'd1;
      end
      if (req1_valid && req1_ready) begin
        grant_cnt1 <= grant_cnt1 + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Round-robin scheduler sharing one registered 8-bit signed arithmetic unit between two requesters.
- Accepts operand/opcode requests over valid/ready, issues a one-cycle start pulse with registered operands, and waits a fixed result latency.
- Captures the unit's 16-bit sign-extended result and returns it with the requester ID over valid/ready.
- Sits between the ALU front-end clients and the arithmetic datapath.

Parameters:
- LAT, 1: cycles from the alu_start cycle's clock edge to a valid alu_result; legal range 1..15.
- OPW, 2: opcode width; forwarded unchanged to the datapath.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted (transfer = valid & ready)
- req0_a, req0_b  in  8 each  signed operands, requester 0
- req0_op  in  OPW  opcode, requester 0
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as above, requester 1
- alu_start  out  1  one-cycle start pulse to the datapath
- alu_a, alu_b  out  8 each  registered signed operands
- alu_op  out  OPW  registered opcode
- alu_result  in  16  signed result from the datapath
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  requester that owns the response
- rsp_result  out  16  captured signed result
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, immediate) puts every output at 0 and the state at IDLE. Internal last_grant resets to 1, so requester 0 wins the first contention.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - reqN_ready is combinational and high only for the chosen requester, only in IDLE.
  - Choice when only one requester is valid: that requester.
  - Choice when both are valid: the requester != last_grant.
  - On transfer: latch a, b, op into alu_a/alu_b/alu_op, latch the ID, update last_grant, go to ISSUE.
  - No valid requester: stay in IDLE, alu_start = 0.
- ISSUE:
  - alu_start = 1 for exactly this one cycle; operands are stable.
  - A wait counter loads LAT-1; go to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - When the counter is 0, sample alu_result into rsp_result on that edge, set rsp_valid = 1, rsp_id = latched ID, go to RESP.
  - With LAT = 1 the result is sampled on the edge ending the first cycle after ISSUE.
- RESP:
  - rsp_valid, rsp_id and rsp_result hold stable until rsp_ready = 1.
  - On the handshake edge: rsp_valid -> 0, go to IDLE.
  - A new request can be accepted no earlier than the following IDLE cycle.
- Throughput, back-to-back with rsp_ready tied high: one operation per LAT + 3 cycles.
- alu_a/alu_b/alu_op hold their last values after ISSUE; the datapath samples them only when alu_start = 1.
- reqN_ready is 0 in ISSUE, WAIT and RESP. Requests arriving then are held by the requester (valid must stay high, payload stable), not dropped.
- A requester deasserting valid before transfer is legal; it is simply not granted.
- The scheduler does no arithmetic; the signedness and 16-bit width of alu_result pass through untouched.
- Reset mid-operation (ISSUE/WAIT/RESP) aborts: the pending result is discarded, rsp_valid = 0 immediately, and no response is ever produced for the aborted request.
- Reset does not require alu_start to have completed; the datapath's own reset handles its state.

Optional Feature:
- Macro: ALU_RR_SCHED_STATS_EN.
- When defined, add two outputs, grant_cnt0 and grant_cnt1 (16 bits each).
  - Each increments on its requester's accept transfer and wraps 0xFFFF -> 0x0000.
  - Both clear on rst.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then single request: req0 a = 5, b = 3, op = 0 with LAT = 1 and the datapath model returning 8.
  - alu_start pulses exactly once, 1 cycle after accept.
  - rsp_valid rises 2 cycles after alu_start rises, with rsp_id = 0 and rsp_result = 0x0008.
- Contention: both requesters valid continuously (req0 a = 1, b = 1; req1 a = -2, b = -3) with rsp_ready held high.
  - Grants alternate 0, 1, 0, 1.
  - Results are 0x0002 and 0xFFFB.
- Backpressure: rsp_ready = 0 for 10 cycles after rsp_valid.
  - rsp_valid, rsp_id and rsp_result stay stable.
  - req0_ready and req1_ready stay 0 throughout.
  - Completion happens on the rsp_ready edge.
- LAT = 4 build: request a = 127, b = 127.
  - Result is sampled exactly 4 cycles after the alu_start edge; a mismatched-timing model value must not appear.
- Mid-operation reset: assert rst asynchronously (between clock edges) during WAIT.
  - All outputs go to 0 without a clock edge.
  - After release, the first contention grants requester 0.
- Stats build: 3 req0 and 2 req1 transfers give grant_cnt0 = 3, grant_cnt1 = 2.
  - Preloading a count to 0xFFFF via force and granting once gives 0x0000.
